// File: rtl/satd_ctrl_if.sv
// satd_ctrl_if: row-buffer read port and SATD datapath port of the SATD
// sequencing controller.
//   mem_rd_en/mem_addr          controller -> row buffers (read request)
//   mem_org_data/mem_cur_data   row buffers -> controller (1 cycle after read)
//   dp_org/dp_cur/dp_valid/
//   dp_first/dp_last            controller -> SATD datapath (row stream)
//   dp_res/dp_res_valid         SATD datapath -> controller (block result)
// modport master: controller side; modport slave: memory/datapath side.
interface satd_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DP_W   = 16
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_org_data;
  logic [63:0]       mem_cur_data;
  logic [63:0]       dp_org;
  logic [63:0]       dp_cur;
  logic              dp_valid;
  logic              dp_first;
  logic              dp_last;
  logic [DP_W-1:0]   dp_res;
  logic              dp_res_valid;

  modport master (
    output mem_rd_en, mem_addr, dp_org, dp_cur, dp_valid, dp_first, dp_last,
    input  mem_org_data, mem_cur_data, dp_res, dp_res_valid
  );

  modport slave (
    input  mem_rd_en, mem_addr, dp_org, dp_cur, dp_valid, dp_first, dp_last,
    output mem_org_data, mem_cur_data, dp_res, dp_res_valid
  );
endinterface

// File: rtl/satd_ctrl.sv
// satd_ctrl: sequences 8x8 blocks from the row buffers into the SATD
// datapath and accumulates a saturating total cost per request.
//   clk, rst           clock, asynchronous active-low reset
//   start              request pulse (sampled in IDLE only)
//   base_addr          row address of block 0 (sampled with start)
//   num_blocks         number of blocks (sampled with start, 0 legal)
//   bus                row-buffer and datapath port (satd_ctrl_if.master)
//   busy               high outside IDLE
//   done               one-cycle completion pulse
//   satd_cost          total cost, valid from done until next start
//   overflow           sticky: accumulator saturated in this request
//   timeout_err        sticky: a block result timed out in this request
module satd_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DP_W    = 16,
  parameter int ACC_W   = 24,
  parameter int TMO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        num_blocks,
  satd_ctrl_if.master       bus,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  satd_cost,
  output logic              overflow,
  output logic              timeout_err
);
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WAIT, S_DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q, mem_addr_q;
  logic [3:0]        blk_q, blk_left_q;
  logic [2:0]        row_q;
  logic              drain_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [ACC_W-1:0]  acc_q, satd_cost_q;
  logic              ovf_q, tmo_err_q, busy_q, done_q;
  logic              mem_rd_en_q, rd_first_q, rd_last_q;
  logic              rd_v1_q, rd_f1_q, rd_l1_q;
  logic              dp_valid_q, dp_first_q, dp_last_q;
  logic [63:0]       dp_org_q, dp_cur_q;

  logic [ACC_W:0]    acc_sum_d;
  logic              sat_d;
  logic [ACC_W-1:0]  cost_d;
  logic [ADDR_W-1:0] next_base_d;

  always_comb begin
    acc_sum_d   = {1'b0, acc_q} + (ACC_W+1)'(bus.dp_res);
    sat_d       = bus.dp_res_valid && acc_sum_d[ACC_W];
    cost_d      = acc_q;
    if (bus.dp_res_valid) cost_d = sat_d ? '1 : acc_sum_d[ACC_W-1:0];
    next_base_d = base_q + ADDR_W'({blk_q + 4'd1, 3'b000});
  end

  // The read address is registered and advanced by one per row, so it is
  // reloaded with base + blk*8 whenever a block's FETCH is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      mem_addr_q  <= '0;
      blk_q       <= '0;
      blk_left_q  <= '0;
      row_q       <= '0;
      drain_q     <= 1'b0;
      tmo_q       <= '0;
      acc_q       <= '0;
      satd_cost_q <= '0;
      ovf_q       <= 1'b0;
      tmo_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      rd_first_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            blk_left_q <= num_blocks;
            blk_q      <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            tmo_err_q  <= 1'b0;
            busy_q     <= 1'b1;
            if (num_blocks == 4'd0) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              satd_cost_q <= '0;
            end else begin
              state_q     <= S_FETCH;
              mem_rd_en_q <= 1'b1;
              rd_first_q  <= 1'b1;
              rd_last_q   <= 1'b0;
              mem_addr_q  <= base_addr;
            end
          end
        end
        S_FETCH: begin
          row_q      <= row_q + 3'd1;
          mem_addr_q <= mem_addr_q + ADDR_W'(1);
          rd_first_q <= 1'b0;
          rd_last_q  <= (row_q == 3'd6);
          if (row_q == 3'd7) begin
            state_q     <= S_DRAIN;
            mem_rd_en_q <= 1'b0;
            rd_last_q   <= 1'b0;
            drain_q     <= 1'b0;
          end
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q <= S_WAIT;
            tmo_q   <= '0;
          end
        end
        S_WAIT: begin
          if (bus.dp_res_valid || tmo_q == TMO_LAST) begin
            acc_q <= cost_d;
            if (sat_d) ovf_q <= 1'b1;
            if (!bus.dp_res_valid) tmo_err_q <= 1'b1;
            blk_left_q <= blk_left_q - 4'd1;
            blk_q      <= blk_q + 4'd1;
            row_q      <= '0;
            if (blk_left_q == 4'd1) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              satd_cost_q <= cost_d;
            end else begin
              state_q     <= S_FETCH;
              mem_rd_en_q <= 1'b1;
              rd_first_q  <= 1'b1;
              mem_addr_q  <= next_base_d;
            end
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Two-stage row pipeline: read data arrives one cycle after the strobe and
  // is registered once more before it is presented to the datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v1_q    <= 1'b0;
      rd_f1_q    <= 1'b0;
      rd_l1_q    <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_first_q <= 1'b0;
      dp_last_q  <= 1'b0;
      dp_org_q   <= '0;
      dp_cur_q   <= '0;
    end else begin
      rd_v1_q    <= mem_rd_en_q;
      rd_f1_q    <= mem_rd_en_q && rd_first_q;
      rd_l1_q    <= mem_rd_en_q && rd_last_q;
      dp_valid_q <= rd_v1_q;
      dp_first_q <= rd_f1_q;
      dp_last_q  <= rd_l1_q;
      if (rd_v1_q) begin
        dp_org_q <= bus.mem_org_data;
        dp_cur_q <= bus.mem_cur_data;
      end
    end
  end

  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.dp_org    = dp_org_q;
  assign bus.dp_cur    = dp_cur_q;
  assign bus.dp_valid  = dp_valid_q;
  assign bus.dp_first  = dp_first_q;
  assign bus.dp_last   = dp_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign satd_cost     = satd_cost_q;
  assign overflow      = ovf_q;
  assign timeout_err   = tmo_err_q;
endmodule

// File: tb/tb_satd_ctrl.sv
// tb_satd_ctrl: scoreboard bench for satd_ctrl. Two instances share the
// stimulus: dut_a with the default 24-bit accumulator and dut_b with a
// 16-bit accumulator (for saturation). Expected reads, rows and per-request
// results are queued when a request is launched and popped as the DUT
// produces them.
module tb_satd_ctrl;
  localparam int ADDR_W  = 10;
  localparam int DP_W    = 16;
  localparam int TMO_CYC = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    int                rel;
  } rd_exp_t;

  typedef struct packed {
    logic [63:0] org;
    logic [63:0] cur;
    logic        first;
    logic        last;
    int          rel;
  } row_exp_t;

  typedef struct packed {
    logic [23:0] cost24;
    logic [15:0] cost16;
    logic        ovf24;
    logic        ovf16;
    logic        tmo;
    int          done_rel;
  } req_exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [3:0]        num_blocks = '0;
  logic              busy_a, done_a, ovf_a, tmo_a;
  logic [23:0]       cost_a;
  logic              busy_b, done_b, ovf_b, tmo_b;
  logic [15:0]       cost_b;

  satd_ctrl_if #(.ADDR_W(ADDR_W), .DP_W(DP_W)) ifa ();
  satd_ctrl_if #(.ADDR_W(ADDR_W), .DP_W(DP_W)) ifb ();

  satd_ctrl #(.ADDR_W(ADDR_W), .DP_W(DP_W), .ACC_W(24), .TMO_CYC(TMO_CYC)) dut_a (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
    .bus(ifa.master), .busy(busy_a), .done(done_a), .satd_cost(cost_a),
    .overflow(ovf_a), .timeout_err(tmo_a)
  );

  satd_ctrl #(.ADDR_W(ADDR_W), .DP_W(DP_W), .ACC_W(16), .TMO_CYC(TMO_CYC)) dut_b (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
    .bus(ifb.master), .busy(busy_b), .done(done_b), .satd_cost(cost_b),
    .overflow(ovf_b), .timeout_err(tmo_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] org_of(input logic [ADDR_W-1:0] a);
    return 64'(a) * 64'h9E37_79B9_7F4A_7C15 + 64'h1111;
  endfunction

  function automatic logic [63:0] cur_of(input logic [ADDR_W-1:0] a);
    return org_of(a) ^ {16'(a), 48'hA5A5_0F0F_3C3C};
  endfunction

  rd_exp_t   addrq[$];
  row_exp_t  rowq[$];
  req_exp_t  expq[$];

  int          cyc = 0;
  int          c0 = 0;
  int          rd_idx = 0;
  int          bidx = 0;
  int          cd = 0;
  int          stray_at = -1000;
  int          done_cnt = 0;
  int          resp_dly = 1;
  bit          resp_on [16];
  logic [15:0] resp_val [16];
  logic [15:0] cd_val = '0;

  // Row-buffer model: one-cycle read latency.
  initial begin
    ifa.mem_org_data = '0; ifa.mem_cur_data = '0;
    ifb.mem_org_data = '0; ifb.mem_cur_data = '0;
    ifa.dp_res = '0; ifa.dp_res_valid = 1'b0;
    ifb.dp_res = '0; ifb.dp_res_valid = 1'b0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifa.mem_rd_en) begin
      ifa.mem_org_data <= org_of(ifa.mem_addr);
      ifa.mem_cur_data <= cur_of(ifa.mem_addr);
    end
    if (ifb.mem_rd_en) begin
      ifb.mem_org_data <= org_of(ifb.mem_addr);
      ifb.mem_cur_data <= cur_of(ifb.mem_addr);
    end
  end

  int       m_r;
  logic     m_rv;
  logic [15:0] m_rd;
  rd_exp_t  m_ae;
  row_exp_t m_re;
  req_exp_t m_e;

  // Monitor and datapath model, all on the falling edge.
  always @(negedge clk) begin
    m_r = cyc - c0 + 1;
    if (rst) begin
      if (ifa.mem_rd_en) begin
        if (addrq.size() == 0) check("unexpected_read", 1, 0);
        else begin
          m_ae = addrq.pop_front();
          check("rd_addr", ifa.mem_addr, m_ae.addr);
          check("rd_cycle", m_r, m_ae.rel);
          check("rd_addr_b", ifb.mem_addr, m_ae.addr);
          m_re.org   = org_of(m_ae.addr);
          m_re.cur   = cur_of(m_ae.addr);
          m_re.first = (rd_idx % 8 == 0);
          m_re.last  = (rd_idx % 8 == 7);
          m_re.rel   = m_r + 2;
          rowq.push_back(m_re);
        end
        rd_idx++;
      end
      if (ifa.dp_valid) begin
        if (rowq.size() == 0) check("unexpected_row", 1, 0);
        else begin
          m_re = rowq.pop_front();
          check("dp_org", ifa.dp_org, m_re.org);
          check("dp_cur", ifa.dp_cur, m_re.cur);
          check("dp_first", ifa.dp_first, m_re.first);
          check("dp_last", ifa.dp_last, m_re.last);
          check("row_cycle", m_r, m_re.rel);
        end
      end
      m_rv = 1'b0;
      m_rd = cd_val;
      if (cd > 0) begin
        cd--;
        if (cd == 0) m_rv = 1'b1;
      end
      if (ifa.dp_valid && ifa.dp_last) begin
        if (bidx < 16 && resp_on[bidx]) begin
          cd     = resp_dly;
          cd_val = resp_val[bidx];
        end
        bidx++;
      end
      if (m_r == stray_at) begin
        m_rv = 1'b1;
        m_rd = 16'h7777;
      end
      ifa.dp_res_valid = m_rv; ifa.dp_res = m_rd;
      ifb.dp_res_valid = m_rv; ifb.dp_res = m_rd;
      if (done_a) begin
        done_cnt++;
        if (expq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          m_e = expq.pop_front();
          check("cost", cost_a, m_e.cost24);
          check("overflow", ovf_a, m_e.ovf24);
          check("timeout_err", tmo_a, m_e.tmo);
          check("done_cycle", m_r, m_e.done_rel);
          check("done_b", done_b, 1);
          check("cost_b", cost_b, m_e.cost16);
          check("overflow_b", ovf_b, m_e.ovf16);
          check("timeout_err_b", tmo_b, m_e.tmo);
          check("reads_left", addrq.size(), 0);
        end
      end
    end
  end

  task automatic clear_resp();
    for (int i = 0; i < 16; i++) begin
      resp_on[i]  = 1'b0;
      resp_val[i] = '0;
    end
  endtask

  // Queue expectations, launch a request, wait for done, check IDLE after.
  task automatic run_req(input logic [ADDR_W-1:0] base, input logic [3:0] n,
                         input int dly, input int pulse_at, input int stray);
    req_exp_t   e;
    rd_exp_t    ae;
    logic [24:0] a24;
    logic [16:0] a16;
    int          p_sum;
    int          d0;
    e = '0;
    p_sum = 0;
    for (int b = 0; b < int'(n); b++) begin
      for (int rr = 0; rr < 8; rr++) begin
        ae.addr = ADDR_W'(int'(base) + b * 8 + rr);
        ae.rel  = 1 + p_sum + rr;
        addrq.push_back(ae);
      end
      if (resp_on[b]) begin
        a24 = {1'b0, e.cost24} + 25'(resp_val[b]);
        if (a24[24]) begin e.cost24 = '1; e.ovf24 = 1'b1; end
        else e.cost24 = a24[23:0];
        a16 = {1'b0, e.cost16} + 17'(resp_val[b]);
        if (a16[16]) begin e.cost16 = '1; e.ovf16 = 1'b1; end
        else e.cost16 = a16[15:0];
        p_sum += 10 + dly;
      end else begin
        e.tmo = 1'b1;
        p_sum += 10 + TMO_CYC;
      end
    end
    e.done_rel = 1 + p_sum;
    expq.push_back(e);
    rd_idx   = 0;
    bidx     = 0;
    resp_dly = dly;
    @(negedge clk);
    base_addr  = base;
    num_blocks = n;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    c0       = cyc;
    stray_at = stray;
    d0 = done_cnt;
    for (int k = 0; k < 400 && done_cnt == d0; k++) begin
      @(negedge clk);
      #1;
      start = (pulse_at >= 0 && (cyc - c0 + 1) == pulse_at);
    end
    start    = 1'b0;
    stray_at = -1000;
    if (done_cnt == d0) check("done_timeout", 0, 1);
    @(negedge clk);
    check("busy_after_done", busy_a, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_resp();
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_mem_rd_en", ifa.mem_rd_en, 0);
    check("rst_mem_addr", ifa.mem_addr, 0);
    check("rst_dp_valid", ifa.dp_valid, 0);
    check("rst_dp_first", ifa.dp_first, 0);
    check("rst_dp_last", ifa.dp_last, 0);
    check("rst_dp_org", ifa.dp_org, 0);
    check("rst_dp_cur", ifa.dp_cur, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_cost", cost_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_timeout_err", tmo_a, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_read", ifa.mem_rd_en, 0);
      check("idle_busy", busy_a, 0);
    end

    // Single block, result two cycles after dp_last.
    clear_resp(); resp_on[0] = 1'b1; resp_val[0] = 16'h0120;
    run_req(10'h010, 4'd1, 2, -1, -1000);

    // Three blocks wrapping the address space.
    clear_resp();
    for (int i = 0; i < 3; i++) begin resp_on[i] = 1'b1; resp_val[i] = 16'd100; end
    run_req(10'h3F8, 4'd3, 1, -1, -1000);

    // Saturation of the 16-bit accumulator.
    clear_resp();
    for (int i = 0; i < 2; i++) begin resp_on[i] = 1'b1; resp_val[i] = 16'hFFFF; end
    run_req(10'h040, 4'd2, 1, -1, -1000);

    // Block 0 times out, block 1 responds.
    clear_resp(); resp_on[1] = 1'b1; resp_val[1] = 16'd50;
    run_req(10'h200, 4'd2, 1, -1, -1000);

    // Zero blocks.
    clear_resp();
    run_req(10'h123, 4'd0, 1, -1, -1000);

    // Start while busy and a stray result during FETCH.
    clear_resp(); resp_on[0] = 1'b1; resp_val[0] = 16'h0042;
    run_req(10'h080, 4'd1, 1, 5, 4);

    // Reset asserted during DRAIN.
    clear_resp(); resp_on[0] = 1'b1; resp_val[0] = 16'd5;
    rd_idx = 0; bidx = 0; resp_dly = 1;
    for (int rr = 0; rr < 8; rr++) begin
      rd_exp_t ae;
      ae.addr = ADDR_W'(10'h100 + rr);
      ae.rel  = 1 + rr;
      addrq.push_back(ae);
    end
    @(negedge clk);
    base_addr = 10'h100; num_blocks = 4'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c0 = cyc;
    repeat (9) @(negedge clk);
    check("drain_busy", busy_a, 1);
    check("drain_dp_valid", ifa.dp_valid, 1);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_dp_valid", ifa.dp_valid, 0);
    check("abort_done", done_a, 0);
    check("abort_cost", cost_a, 0);
    rowq.delete();
    addrq.delete();
    cd = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_idle_busy", busy_a, 0);

    // Recovery after abort.
    clear_resp(); resp_on[0] = 1'b1; resp_val[0] = 16'd7;
    run_req(10'h300, 4'd1, 1, -1, -1000);

    check("pending_results", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
